seg_scan_decoder: RTL

Receive-side counterpart of the board's multiplexed seven-segment driver: samples the `an`/`seg` scan outputs and rebuilds the four displayed hex digits, decimal points and per-digit validity. It sits in the board top as a loopback/self-check monitor and also serves as the display checker in block benches. It flags illegal anode patterns and unrecognised segment codes, and emits one strobe per fully observed scan frame.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_glyph_decode.sv | 28 ++
 rtl/seg_scan_decoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan monitor.
// Holds the segment bit positions, the active-high glyph table for hex digits 0-F,
// the blank pattern and the scan FSM state type.
package seg_pkg;

  // Segment bit positions within the 8-bit seg bus
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba pattern for each nibble; entry 15 is listed first
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

  typedef enum logic [1:0] {
    StIdle,    // zero or several anodes active
    StSettle,  // one anode active, waiting for stable inputs
    StHeld     // digit captured, waiting for the next change
  } seg_state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment glyph decoder.
// Ports:
//   pattern : active-high gfedcba segment pattern
//   known   : pattern matches one of the 16 hex glyphs
//   blank   : all segments off
//   nibble  : decoded hex value (0 when not known)
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       known,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    known  = 1'b0;
    nibble = 4'h0;
    blank  = (pattern == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        known  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan monitor: samples multiplexed an/seg lines and rebuilds the four
// displayed hex digits, decimal points and per-digit validity.
// Parameters:
//   SETTLE_CYCLES : cycles {an,seg} must stay unchanged before a digit is captured (1..255)
//   ACTIVE_LOW    : 1 when an/seg are active-low
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   seg[7:0]      : segment lines, bit0=a .. bit6=g, bit7=dp
//   an[3:0]       : anode enables, bit i selects digit i (digit 0 rightmost)
//   digits[15:0]  : decoded nibbles, [4i+3:4i] is digit i
//   dp[3:0]       : decimal point lit per digit
//   valid[3:0]    : digit decoded to a legal glyph
//   frame_done    : pulse when digits/dp/valid load
//   err_anode     : pulse on entry to a multi-anode state
//   err_pattern   : pulse on capture of an unknown glyph
// Optional (macro SEG_SCAN_STATS_EN):
//   frame_cnt[15:0] : wrapping count of frame_done pulses
//   err_cnt[15:0]   : wrapping count of err_anode + err_pattern pulses
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        err_anode,
  output logic        err_pattern
`ifdef SEG_SCAN_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  // Input stage, stored already normalised to active-high
  logic [3:0] an_q, an_p;
  logic [7:0] seg_q, seg_p;
  logic [7:0] cnt_q, cnt_d;

  seg_state_e state_q, state_d;

  logic       change, an_moved, one_hot, multi;
  logic [2:0] an_cnt;
  logic       capture, anode_err;

  logic       glyph_known, glyph_blank;
  logic [3:0] glyph_nibble;

  logic [3:0][3:0] sh_dig_q, sh_dig_d;
  logic [3:0]      sh_dp_q, sh_dp_d;
  logic [3:0]      sh_val_q, sh_val_d;
  logic [3:0]      seen_q, seen_d;
  logic [1:0]      dig_idx;
  logic            frame_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '0;
      seg_q <= '0;
      an_p  <= '0;
      seg_p <= '0;
      cnt_q <= '0;
    end else begin
      an_q  <= an ^ {4{ACTIVE_LOW}};
      seg_q <= seg ^ {8{ACTIVE_LOW}};
      an_p  <= an_q;
      seg_p <= seg_q;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    an_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      an_cnt = an_cnt + 3'(an_q[i]);
    end
  end

  assign change   = {an_q, seg_q} != {an_p, seg_p};
  assign an_moved = an_q != an_p;
  assign one_hot  = an_cnt == 3'd1;
  assign multi    = an_cnt > 3'd1;

  always_comb begin
    if (change) begin
      cnt_d = '0;
    end else if (cnt_q >= SettleMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; any input change re-evaluates the anode set from scratch
  always_comb begin
    state_d = state_q;
    if (change) begin
      state_d = one_hot ? StSettle : StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StSettle: if (cnt_q >= SettleLast) state_d = StHeld;
        StHeld:   state_d = StHeld;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs. Capture fires on the edge where cnt reaches SETTLE_CYCLES.
  always_comb begin
    capture   = (state_q == StSettle) && !change && (cnt_q >= SettleLast);
    anode_err = change && an_moved && multi;
  end

  seg_glyph_decode u_glyph_decode (
    .pattern (seg_q[SEG_G:SEG_A]),
    .known   (glyph_known),
    .blank   (glyph_blank),
    .nibble  (glyph_nibble)
  );

  // Shadow update; the completing capture is merged before the frame loads
  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (an_q[i]) dig_idx = 2'(i);
    end
    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_val_d   = sh_val_q;
    seen_d     = seen_q;
    frame_load = 1'b0;
    if (capture) begin
      sh_dig_d[dig_idx] = glyph_known ? glyph_nibble : 4'h0;
      sh_dp_d[dig_idx]  = seg_q[SEG_DP];
      sh_val_d[dig_idx] = glyph_known;
      seen_d            = seen_q | an_q;
      if (seen_d == 4'hF) begin
        frame_load = 1'b1;
        seen_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      sh_val_q    <= '0;
      seen_q      <= '0;
      digits      <= '0;
      dp          <= '0;
      valid       <= '0;
      frame_done  <= 1'b0;
      err_anode   <= 1'b0;
      err_pattern <= 1'b0;
    end else begin
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      sh_val_q    <= sh_val_d;
      seen_q      <= seen_d;
      frame_done  <= frame_load;
      err_anode   <= anode_err;
      err_pattern <= capture && !glyph_known && !glyph_blank;
      if (frame_load) begin
        digits <= sh_dig_d;
        dp     <= sh_dp_d;
        valid  <= sh_val_d;
      end
    end
  end

`ifdef SEG_SCAN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_cnt <= frame_cnt + 16'(frame_done);
      err_cnt   <= err_cnt + 16'(err_anode) + 16'(err_pattern);
    end
  end
`endif

endmodule
